// File: rtl/laser_feeder.sv
// laser_feeder: buffers a frame of 4-bit x/y points, streams it to a solver
// after the solver raises DONE, then captures the solver's result on the next
// DONE. A per-state cycle counter flags a sticky timeout if the solver stalls.
module laser_feeder #(
  parameter int unsigned NPTS    = 40,
  parameter int unsigned TIMEOUT = 32767
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LD_EN,
  input  logic [3:0] LD_X,
  input  logic [3:0] LD_Y,
  input  logic       START,
  input  logic       DONE,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  output logic [3:0] X,
  output logic [3:0] Y,
  output logic       LD_FULL,
  output logic       BUSY,
  output logic [3:0] R_C1X,
  output logic [3:0] R_C1Y,
  output logic [3:0] R_C2X,
  output logic [3:0] R_C2Y,
  output logic       RES_VALID,
  output logic       TMO_ERR
);

  localparam int unsigned PW = $clog2(NPTS + 1);
  localparam int unsigned AW = (NPTS > 1) ? $clog2(NPTS) : 1;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SEND, S_WAIT} state_t;

  state_t          state_q;
  state_t          state_d;
  logic [PW-1:0]   wptr_q;
  logic [PW-1:0]   k_q;
  logic [CW-1:0]   cnt_q;
  logic [7:0]      frame_mem [NPTS];

  logic            ld_we;
  logic            send_first;
  logic            send_step;
  logic            capture;
  logic            tmo_fire;
  logic            cnt_clr;
  logic            tmo_hit;

  // Full flag follows the write pointer directly so START sees the pre-write value
  assign LD_FULL = (wptr_q == PW'(NPTS));
  assign tmo_hit = (cnt_q == CW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and datapath control decode; DONE outranks the timeout
  always_comb begin
    state_d    = state_q;
    ld_we      = 1'b0;
    send_first = 1'b0;
    send_step  = 1'b0;
    capture    = 1'b0;
    tmo_fire   = 1'b0;
    case (state_q)
      S_IDLE: begin
        ld_we = LD_EN && !LD_FULL;
        if (START && LD_FULL) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (DONE) begin
          send_first = 1'b1;
          state_d    = S_SEND;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_SEND: begin
        if (k_q < PW'(NPTS)) send_step = 1'b1;
        else                 state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (DONE) begin
          capture = 1'b1;
          state_d = S_IDLE;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    cnt_clr = ((state_d == S_ARMED) && (state_q != S_ARMED)) ||
              ((state_d == S_WAIT)  && (state_q != S_WAIT));
  end

  // Status outputs decoded from the state register
  always_comb begin
    BUSY = (state_q != S_IDLE);
  end

  // Frame buffer write; contents survive reset and captures
  always_ff @(posedge CLK) begin
    if (!RST && ld_we) frame_mem[AW'(wptr_q)] <= {LD_X, LD_Y};
  end

  // Pointers, cycle counter, point stream and result capture
  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_q    <= '0;
      k_q       <= '0;
      cnt_q     <= '0;
      X         <= '0;
      Y         <= '0;
      R_C1X     <= '0;
      R_C1Y     <= '0;
      R_C2X     <= '0;
      R_C2Y     <= '0;
      RES_VALID <= 1'b0;
      TMO_ERR   <= 1'b0;
    end else begin
      RES_VALID <= capture;
      X         <= '0;
      Y         <= '0;

      if (capture || tmo_fire) wptr_q <= '0;
      else if (ld_we)          wptr_q <= wptr_q + PW'(1);

      if (send_first) begin
        {X, Y} <= frame_mem[0];
        k_q    <= PW'(1);
      end else if (send_step) begin
        {X, Y} <= frame_mem[AW'(k_q)];
        k_q    <= k_q + PW'(1);
      end

      if (cnt_clr)                                        cnt_q <= '0;
      else if ((state_q == S_ARMED) || (state_q == S_WAIT)) cnt_q <= cnt_q + CW'(1);

      if (tmo_fire) TMO_ERR <= 1'b1;

      if (capture) begin
        R_C1X <= C1X;
        R_C1Y <= C1Y;
        R_C2X <= C2X;
        R_C2Y <= C2Y;
      end
    end
  end

endmodule
